// File: rtl/gpu_pixel_writer_pkg.sv
// Shared definitions for the framebuffer pixel writer.
// The display geometry macros normally come from gpu_definitions.vh; the
// guarded block below carries the same values (plus the framebuffer address
// width) so this slice elaborates on its own and never redefines them.
`ifndef GPU_DEFINITIONS_VH
`define GPU_DEFINITIONS_VH
`define WIDTH        640
`define HEIGHT       480
`define WIDTH_BITS   10
`define HEIGHT_BITS  9
`define CHANNEL_BITS 8
`define FB_ADDR_BITS 19
`endif

package gpu_pixel_writer_pkg;

  // Width used for full-precision address arithmetic before truncation.
  localparam int CALC_BITS = 32;

  // Linear framebuffer address: base + y*WIDTH + x, not yet truncated.
  function automatic logic [CALC_BITS-1:0] fb_linear_addr(
    input logic [CALC_BITS-1:0] base,
    input logic [CALC_BITS-1:0] x,
    input logic [CALC_BITS-1:0] y
  );
    return base + y * CALC_BITS'(`WIDTH) + x;
  endfunction

  // A pixel is on screen iff both coordinates are strictly inside the frame.
  function automatic logic pix_in_range(
    input logic [CALC_BITS-1:0] x,
    input logic [CALC_BITS-1:0] y
  );
    return (x < CALC_BITS'(`WIDTH)) && (y < CALC_BITS'(`HEIGHT));
  endfunction

  // Saturating 16-bit increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gpu_pixel_writer_fifo.sv
// Small synchronous FIFO holding {addr, data} entries for the pixel writer.
// Exposes both the head and the entry behind it so the write FSM can issue
// back-to-back requests without a bubble.
module gpu_pixel_fifo #(
  parameter int DATA_BITS = 43,
  parameter int DEPTH     = 4,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] din_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] head_o,
  output logic [DATA_BITS-1:0] second_o,
  output logic [CNT_BITS-1:0]  count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]  r_wr_ptr;
  logic [PTR_BITS-1:0]  r_rd_ptr;
  logic [CNT_BITS-1:0]  r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  assign full_o   = (r_count == CNT_BITS'(DEPTH));
  assign empty_o  = (r_count == '0);
  assign count_o  = r_count;
  assign head_o   = r_mem[r_rd_ptr];
  assign second_o = r_mem[r_rd_ptr + PTR_BITS'(1)];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Framebuffer write stage: range-checks incoming pixels, converts them to a
// linear address plus packed colour, buffers them and drains them to SRAM
// one write per pixel over a req/ack port.
module gpu_pixel_writer
  import gpu_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = `FB_ADDR_BITS,
  parameter int PIXEL_BITS = 3*`CHANNEL_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  input  logic [`WIDTH_BITS-1:0]   x_i,
  input  logic [`HEIGHT_BITS-1:0]  y_i,
  input  logic [`CHANNEL_BITS-1:0] r_i,
  input  logic [`CHANNEL_BITS-1:0] g_i,
  input  logic [`CHANNEL_BITS-1:0] b_i,
  input  logic [ADDR_BITS-1:0]     frame_base_i,
  output logic                     mem_req_o,
  output logic [ADDR_BITS-1:0]     mem_addr_o,
  output logic [PIXEL_BITS-1:0]    mem_wdata_o,
  input  logic                     mem_ack_i,
  output logic                     busy_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int ENTRY_BITS = ADDR_BITS + PIXEL_BITS;
  localparam int CNT_BITS   = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_BITS-1:0]  r_mem_addr;
  logic [ADDR_BITS-1:0]  w_addr_next;
  logic [PIXEL_BITS-1:0] r_mem_wdata;
  logic [PIXEL_BITS-1:0] w_data_next;
  logic [15:0]           r_drop_cnt;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [ADDR_BITS-1:0]  w_pix_addr;
  logic [PIXEL_BITS-1:0] w_pix_data;
  logic [ENTRY_BITS-1:0] w_head;
  logic [ENTRY_BITS-1:0] w_second;
  logic [CNT_BITS-1:0]   w_count;
  logic                  w_full;
  logic                  w_empty;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for that cycle's push.
  assign pix_ready_o = !w_full;
  assign w_accept    = pix_valid_i && pix_ready_o;
  assign w_in_range  = pix_in_range(CALC_BITS'(x_i), CALC_BITS'(y_i));
  assign w_push      = w_accept && w_in_range;
  assign w_drop      = w_accept && !w_in_range;

  // Address wraps modulo 2^ADDR_BITS; colour is {r,g,b} with r on top.
  assign w_pix_addr = ADDR_BITS'(fb_linear_addr(CALC_BITS'(frame_base_i),
                                                CALC_BITS'(x_i),
                                                CALC_BITS'(y_i)));
  assign w_pix_data = PIXEL_BITS'({r_i, g_i, b_i});

  gpu_pixel_fifo #(
    .DATA_BITS (ENTRY_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push_i   (w_push),
    .din_i    ({w_pix_addr, w_pix_data}),
    .pop_i    (w_pop),
    .head_o   (w_head),
    .second_o (w_second),
    .count_o  (w_count),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  // Next-state and write-port loading; the entry being written stays in the
  // FIFO until acked, so "another entry" means count > 1.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_mem_addr;
    w_data_next  = r_mem_wdata;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next               = ST_REQ;
          {w_addr_next, w_data_next} = w_head;
        end
      end
      ST_REQ: begin
        if (mem_ack_i) begin
          w_pop = 1'b1;
          if (w_count > CNT_BITS'(1)) begin
            {w_addr_next, w_data_next} = w_second;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Write address/data registers, held stable while a request is pending.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_addr  <= w_addr_next;
      r_mem_wdata <= w_data_next;
    end
  end

  // Saturating count of off-screen pixels that were accepted and discarded.
  always_ff @(posedge clk) begin
    if (!n_rst)      r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
  end

  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign busy_o      = (r_state == ST_REQ) || !w_empty;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer: directed table, hand sequences
// for latency/back-pressure/reset corners, and a randomized phase checked
// against a queue-based reference of expected framebuffer writes.
`ifndef GPU_DEFINITIONS_VH
`define GPU_DEFINITIONS_VH
`define WIDTH        640
`define HEIGHT       480
`define WIDTH_BITS   10
`define HEIGHT_BITS  9
`define CHANNEL_BITS 8
`define FB_ADDR_BITS 19
`endif

module tb_gpu_pixel_writer;

  localparam int W     = `WIDTH;
  localparam int H     = `HEIGHT;
  localparam int AB    = `FB_ADDR_BITS;
  localparam int CB    = `CHANNEL_BITS;
  localparam int PB    = 3*CB;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     n_rst;
  logic                     pix_valid_i;
  logic                     pix_ready_o;
  logic [`WIDTH_BITS-1:0]   x_i;
  logic [`HEIGHT_BITS-1:0]  y_i;
  logic [CB-1:0]            r_i, g_i, b_i;
  logic [AB-1:0]            frame_base_i;
  logic                     mem_req_o;
  logic [AB-1:0]            mem_addr_o;
  logic [PB-1:0]            mem_wdata_o;
  logic                     mem_ack_i;
  logic                     busy_o;
  logic [15:0]              drop_cnt_o;

  always #5 clk = ~clk;

  gpu_pixel_writer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_BITS  (AB),
    .PIXEL_BITS (PB)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .x_i          (x_i),
    .y_i          (y_i),
    .r_i          (r_i),
    .g_i          (g_i),
    .b_i          (b_i),
    .frame_base_i (frame_base_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .busy_o       (busy_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [PB-1:0] data;
  } wr_t;

  typedef struct {
    int     x;
    int     y;
    int     r;
    int     g;
    int     b;
    longint base;
    bit     wr;
    longint addr;
    longint data;
  } vec_t;

  int      n_checks = 0;
  int      n_pass   = 0;
  bit      mon_en   = 1'b0;
  wr_t     exp_q[$];
  int      exp_drop = 0;
  int      wr_count = 0;
  int      busy_cycles = 0;
  logic [AB-1:0] last_addr;
  logic [PB-1:0] last_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  // Reference: what a pixel should become in the framebuffer.
  function automatic wr_t model_write(int x, int y, int r, int g, int b, longint base);
    wr_t    m;
    longint a;
    a = (base + longint'(y) * W + x) % (longint'(1) << AB);
    m.addr = AB'(a);
    m.data = PB'((r << (2*CB)) | (g << CB) | b);
    return m;
  endfunction

  // Scoreboard: sampled on the falling edge, describes the upcoming rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready", pix_ready_o, exp_q.size() != DEPTH);
      check("busy", busy_o, exp_q.size() != 0);
      check("drop_cnt", drop_cnt_o, exp_drop);
      if (mem_req_o) begin
        if (exp_q.size() == 0) begin
          check("req_spurious", 1, 0);
        end else begin
          check("wr_addr", mem_addr_o, exp_q[0].addr);
          check("wr_data", mem_wdata_o, exp_q[0].data);
        end
      end
      if (!n_rst) begin
        exp_q.delete();
        exp_drop = 0;
      end else begin
        if (busy_o) busy_cycles++;
        if (mem_req_o && mem_ack_i) begin
          wr_count++;
          last_addr = mem_addr_o;
          last_data = mem_wdata_o;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (pix_valid_i && pix_ready_o) begin
          if (int'(x_i) < W && int'(y_i) < H)
            exp_q.push_back(model_write(int'(x_i), int'(y_i), int'(r_i), int'(g_i),
                                        int'(b_i), longint'(frame_base_i)));
          else if (exp_drop < 65535)
            exp_drop++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input int r, input int g, input int b,
                         input longint base);
    x_i          = `WIDTH_BITS'(x);
    y_i          = `HEIGHT_BITS'(y);
    r_i          = CB'(r);
    g_i          = CB'(g);
    b_i          = CB'(b);
    frame_base_i = AB'(base);
  endtask

  // Offer one pixel until it is accepted (bounded).
  task automatic send(input int x, input int y, input int r, input int g, input int b,
                      input longint base);
    bit acc;
    bit rdy;
    acc = 1'b0;
    set_pix(x, y, r, g, b, base);
    pix_valid_i = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rdy = pix_ready_o;
      step();
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    pix_valid_i = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    for (int k = 0; k < bound && busy_o; k++) step();
    check(nm, busy_o, 0);
  endtask

  vec_t vecs[8];
  int   wr0;
  int   bc0;
  int   tbl_drops;

  initial begin
    vecs[0] = '{3,       2,       1,    2,    3,    0,         1'b1, 2*W+3,   32'h010203};
    vecs[1] = '{W-1,     H-1,     8'hFF, 0,   8'h80, 0,        1'b1, W*H-1,   32'hFF0080};
    vecs[2] = '{0,       H,       5,    6,    7,    0,         1'b0, 0,       0};
    vecs[3] = '{W,       0,       5,    6,    7,    0,         1'b0, 0,       0};
    vecs[4] = '{1,       0,       9,    9,    9,    (1<<AB)-1, 1'b1, 0,       32'h090909};
    vecs[5] = '{W-1,     0,       8'h12, 8'h34, 8'h56, 100,    1'b1, 739,     32'h123456};
    vecs[6] = '{1023,    511,     1,    1,    1,    0,         1'b0, 0,       0};
    vecs[7] = '{0,       H-1,     8'hA5, 8'h5A, 8'h0F, 'h7FF00, 1'b1, 'h4AC80, 32'hA55A0F};

    n_rst = 1'b0; pix_valid_i = 1'b0; mem_ack_i = 1'b0;
    set_pix(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_ready", pix_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    n_rst = 1'b1;
    mon_en = 1'b1;

    // Single pixel latency: request appears after edge N+1, lasts one cycle.
    mem_ack_i = 1'b1;
    set_pix(3, 2, 1, 2, 3, 0);
    pix_valid_i = 1'b1;
    step();
    pix_valid_i = 1'b0;
    check("lat_n_req", mem_req_o, 0);
    step();
    check("lat_n1_req", mem_req_o, 1);
    check("lat_n1_addr", mem_addr_o, 2*W+3);
    check("lat_n1_data", mem_wdata_o, 24'h010203);
    step();
    check("lat_n2_req", mem_req_o, 0);
    check("lat_n2_busy", busy_o, 0);

    // Directed table, one pixel at a time with ack held high.
    tbl_drops = 0;
    for (int i = 0; i < 8; i++) begin
      wr0 = wr_count;
      set_pix(vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].base);
      pix_valid_i = 1'b1;
      step();
      pix_valid_i = 1'b0;
      wait_idle("tbl_idle", 20);
      if (!vecs[i].wr) tbl_drops++;
      check($sformatf("tbl%0d_writes", i), wr_count - wr0, vecs[i].wr ? 1 : 0);
      check($sformatf("tbl%0d_drops", i), drop_cnt_o, tbl_drops);
      if (vecs[i].wr) begin
        check($sformatf("tbl%0d_addr", i), last_addr, vecs[i].addr);
        check($sformatf("tbl%0d_data", i), last_data, vecs[i].data);
      end
    end

    // Back-pressure: fill with ack low, then drain 8 writes back-to-back.
    mem_ack_i = 1'b0;
    wr0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      send(10 + i, 20, i, i + 1, i + 2, 0);
      check($sformatf("bp_ready%0d", i), pix_ready_o, (i < 3) ? 1 : 0);
    end
    repeat (3) step();
    check("bp_stall_writes", wr_count - wr0, 0);
    check("bp_stall_ready", pix_ready_o, 0);
    bc0 = busy_cycles;
    mem_ack_i = 1'b1;
    for (int i = 4; i < 8; i++) send(10 + i, 20, i, i + 1, i + 2, 0);
    wait_idle("bp_idle", 20);
    check("bp_writes", wr_count - wr0, 8);
    check("bp_no_bubble", busy_cycles - bc0, 8);
    check("bp_last_addr", last_addr, 20*W + 17);

    // Randomized traffic against the queue reference.
    for (int c = 0; c < 600; c++) begin
      int xv, yv;
      xv = $urandom_range(0, W-1);
      yv = $urandom_range(0, H-1);
      case ($urandom_range(0, 9))
        0: xv = W + $urandom_range(0, 383);
        1: yv = H + $urandom_range(0, 31);
        default: ;
      endcase
      set_pix(xv, yv, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), longint'($urandom_range(0, (1<<AB)-1)));
      pix_valid_i = ($urandom_range(0, 3) != 0);
      mem_ack_i   = ($urandom_range(0, 2) != 0);
      step();
    end
    pix_valid_i = 1'b0;
    mem_ack_i   = 1'b1;
    wait_idle("rand_idle", 50);
    check("rand_drained", exp_q.size(), 0);

    // Reset during an outstanding request with an ack in the same cycle.
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) send(i, 7, 4, 5, 6, 0);
    check("mid_pre_req", mem_req_o, 1);
    n_rst     = 1'b0;
    mem_ack_i = 1'b1;
    step();
    check("mid_req", mem_req_o, 0);
    check("mid_busy", busy_o, 0);
    check("mid_ready", pix_ready_o, 1);
    check("mid_drop", drop_cnt_o, 0);
    n_rst = 1'b1;
    wr0 = wr_count;
    repeat (5) step();
    check("mid_no_writes", wr_count - wr0, 0);

    // Drop-counter saturation.
    set_pix(W, 0, 0, 0, 0, 0);
    pix_valid_i = 1'b1;
    repeat (65540) step();
    pix_valid_i = 1'b0;
    step();
    check("sat_drop", drop_cnt_o, 16'hFFFF);
    check("sat_busy", busy_o, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Framebuffer write stage sitting directly downstream of the GPU's rectangle-fill pixel generator. It accepts (x, y, r, g, b) pixels via a valid/ready handshake and buffers them in a small FIFO. It converts each in-range pixel to a linear framebuffer address and packs its colour into a word. It then issues one SRAM write per pixel over a req/ack memory port. Out-of-range pixels, including the one-row overrun the fill generator may emit at y == HEIGHT, are discarded and counted.

## Interface
Parameters:
- FIFO_DEPTH, 4: pixel buffer entries; power of two, ≥ 2.
- ADDR_BITS, 19: framebuffer word address width.
- PIXEL_BITS, 3*`CHANNEL_BITS: packed colour width, {r,g,b}, r in the MSBs.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state updates on posedge.
- n_rst  in  1  synchronous active-low reset, sampled on posedge clk.
- pix_valid_i  in  1  pixel present on x_i/y_i/r_i/g_i/b_i.
- pix_ready_o  out  1  buffer can accept a pixel this cycle.
- x_i  in  `WIDTH_BITS  pixel column.
- y_i  in  `HEIGHT_BITS  pixel row.
- r_i, g_i, b_i  in  `CHANNEL_BITS each  pixel colour.
- frame_base_i  in  ADDR_BITS  base address of the target buffer, sampled at pixel acceptance.
- mem_req_o  out  1  write request.
- mem_addr_o  out  ADDR_BITS  write address.
- mem_wdata_o  out  PIXEL_BITS  write data.
- mem_ack_i  in  1  memory accepted the current write; ignored while mem_req_o is low.
- busy_o  out  1  FIFO non-empty or a write is outstanding.
- drop_cnt_o  out  16  saturating count of discarded out-of-range pixels.

## Operation
- Acceptance: a pixel is accepted on a posedge where pix_valid_i && pix_ready_o.
- pix_ready_o = (count != FIFO_DEPTH), from the registered count. A pop in the same cycle does not free a slot for that cycle's push.
- Range check at acceptance: the pixel is in range iff x_i < `WIDTH and y_i < `HEIGHT.
  - In range: enqueue {addr, data}.
  - Out of range: not enqueued; drop_cnt_o increments, saturating at 16'hFFFF.
- Address: addr = frame_base_i + y_i*`WIDTH + x_i, computed at full precision and truncated to ADDR_BITS (wraps modulo 2^ADDR_BITS).
- Data: data = {r_i, g_i, b_i}.
- Write FSM, two states:
  - IDLE: mem_req_o = 0. If count != 0, load the head entry into mem_addr_o/mem_wdata_o and go to REQ.
  - REQ: mem_req_o = 1; addr/data are held stable until acknowledged. On mem_ack_i:
    - Pop the head.
    - If another entry exists, load it and stay in REQ. This gives back-to-back writes at one per cycle when ack is held high.
    - Otherwise go to IDLE.
- FIFO occupancy includes the entry currently being written; it is freed only on ack.
- busy_o = (state == REQ) || (count != 0).
- Ordering: memory writes occur in acceptance order. There is no reordering or merging.

## Timing
- Reset (n_rst low at a posedge), applied to all outputs:
  - mem_req_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - pix_ready_o = 1, busy_o = 0, drop_cnt_o = 0.
  - FIFO empty, FSM in IDLE.
- Reset mid-write abandons the outstanding request. mem_req_o drops after that edge, and an ack arriving in the same cycle is ignored.
- Latency: a pixel accepted at edge N into an empty FIFO with the FSM in IDLE produces mem_req_o = 1 with its addr/data after edge N+1.
- Ack at edge M with further entries queued: the next addr/data are valid after edge M, with no bubble.
- Simultaneous push and pop when not full: count is unchanged and both actions take effect.
- Simultaneous push and pop when full: the push is refused (pix_ready_o = 0).
- Drop-counter saturation holds at 16'hFFFF; further drops are lost silently.
- Boundary pixels:
  - x = `WIDTH-1, y = `HEIGHT-1 is written.
  - x = `WIDTH or y = `HEIGHT is dropped.

## Structure
- gpu_definitions.vh already supplies `WIDTH, `HEIGHT, `WIDTH_BITS, `HEIGHT_BITS and `CHANNEL_BITS. Add `FB_ADDR_BITS there and use it as the default for ADDR_BITS.
- The FSM state encoding is local to this module.
- One sub-module: gpu_pixel_fifo, a parameterised synchronous FIFO with push/pop/count/full/empty, width ADDR_BITS+PIXEL_BITS, depth FIFO_DEPTH.
- Address arithmetic and the FSM stay in the top module.

## Test plan
- Reset, then a single pixel x=3, y=2, frame_base=0, rgb=(1,2,3), ack tied high -> mem_req_o high for exactly one cycle starting after edge N+1; addr = 2*`WIDTH+3, wdata = {1,2,3}; busy_o returns to 0.
- Stream 8 pixels with ack held low -> pix_ready_o falls after the 4th acceptance and no pixel is lost. Raise ack -> 8 writes in order, back-to-back, one per cycle while queued.
- Pixels at (`WIDTH-1, `HEIGHT-1) and (0, `HEIGHT) -> the first is written to addr `WIDTH*`HEIGHT-1; the second is dropped and drop_cnt_o = 1.
- frame_base_i = 2^ADDR_BITS-1, pixel (1,0) -> mem_addr_o = 0 (wrap).
- Assert n_rst low during REQ with 3 entries queued and mem_ack_i high in the same cycle -> after the edge mem_req_o = 0, busy_o = 0, pix_ready_o = 1, and no further writes occur.
- Force 65,536 out-of-range pixels -> drop_cnt_o saturates at 16'hFFFF.
